// File: rtl/sevenseg_scan.sv
// Time-multiplexed DIGITS-digit seven-segment driver; updates latch at frame boundaries only.
// Optional leading-zero blanking via SEVENSEG_LZB_EN.
module sevenseg_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 100000,
  parameter int CW       = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [6:0]            segments,
  output logic                  decimal_point,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] PCNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic                pend_flag_q, pend_flag_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic                frame_done_q, frame_done_d;

  logic                dwell_end, wrap;
  logic [3:0]          nibble;
  logic                auto_blank;

  always_comb begin
    dwell_end = (pcnt_q == PCNT_LAST);
    wrap      = dwell_end && (idx_q == IDX_LAST);

    pcnt_d = dwell_end ? '0 : pcnt_q + CW'(1);
    idx_d  = idx_q;
    if (dwell_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_flag_d  = pend_flag_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;

    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_blank_d = blank;
      pend_flag_d  = 1'b1;
    end

    // A load landing on the wrap bypasses pending so it is not delayed a whole frame.
    if (wrap) begin
      if (load) begin
        act_val_d   = value;
        act_dp_d    = dp_in;
        act_blank_d = blank;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        act_val_d   = pend_val_q;
        act_dp_d    = pend_dp_q;
        act_blank_d = pend_blank_q;
        pend_flag_d = 1'b0;
      end
    end
  end

`ifdef SEVENSEG_LZB_EN
  logic [DIGITS-1:0] upper_zero;
  logic              zero_acc;

  always_comb begin
    upper_zero = '0;
    zero_acc   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_acc      = zero_acc && (act_val_d[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_acc;
    end
    auto_blank = (idx_d != '0) && upper_zero[idx_d];
  end
`else
  always_comb begin
    auto_blank = 1'b0;
  end
`endif

  // Output pins are computed from next-state index/data so they change with the scan.
  always_comb begin
    nibble       = act_val_d[{idx_d, 2'b00} +: 4];
    seg_d        = hex7(nibble);
    dp_d         = ~act_dp_d[idx_d];
    if (act_blank_d[idx_d] || auto_blank) begin
      seg_d = 7'h7F;
    end
    if (act_blank_d[idx_d]) begin
      dp_d = 1'b1;
    end
    anode_d        = '1;
    anode_d[idx_d] = 1'b0;
    frame_done_d   = wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_flag_q  <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      anode_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_flag_q  <= pend_flag_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segments      = seg_q;
  assign decimal_point = dp_q;
  assign anode         = anode_q;
  assign frame_done    = frame_done_q;
  assign busy          = pend_flag_q;

endmodule
